// File: rtl/mem_arbiter.sv
// Two-master (I-cache, D-cache) to one memory port arbiter with turnaround.
// Define MEM_ARB_RR_EN for round-robin tie-break instead of D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   req_i, req_d, pick_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;

  // On a tie, the master that did not win last time goes first
  assign pick_d = req_d & (~req_i | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (state_d == GNT_D) last_d_d = 1'b1;
      else if (state_d == GNT_I) last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) last_d_q <= 1'b0;
    else               last_d_q <= last_d_d;
  end
`else
  assign pick_d = req_d;
`endif

  always_ff @(posedge clk) begin
    if (!proc_reset_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d)     state_d = GNT_D;
        else if (req_i) state_d = GNT_I;
      end
      GNT_I: begin
        if (mem_ready)   state_d = TURN;
        else if (!req_i) state_d = IDLE;
      end
      GNT_D: begin
        if (mem_ready)   state_d = TURN;
        else if (!req_d) state_d = IDLE;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    grant       = 2'b00;
    unique case (state_q)
      GNT_I: begin
        mem_read    = i_mem_read;
        mem_write   = i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        // A ready arriving in the reset cycle is dropped with the grant
        i_mem_ready = mem_ready & proc_reset_n;
        grant       = 2'b01;
      end
      GNT_D: begin
        mem_read    = d_mem_read;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready & proc_reset_n;
        grant       = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single 128-bit memory port between the instruction cache and the data cache. Each cache drives its normal level-held mem_read/mem_write request and waits for mem_ready. The arbiter grants one cache at a time, forwards its request to memory, and routes mem_ready back to that cache only. It inserts one idle turnaround cycle between transactions.

Parameters:
ADDR_W, 28, block address width (word address minus 2-bit word offset)
DATA_W, 128, block data width (4 x 32-bit words)

Ports:
clk  input  1  clock; all state updates on rising edge
proc_reset_n  input  1  reset, synchronous, active-low
i_mem_read  input  1  I-cache read request, held until its i_mem_ready
i_mem_write  input  1  I-cache write request (normally 0)
i_mem_addr  input  ADDR_W  I-cache block address
i_mem_wdata  input  DATA_W  I-cache write block
i_mem_rdata  output  DATA_W  read block to I-cache
i_mem_ready  output  1  completion pulse to I-cache
d_mem_read  input  1  D-cache read request
d_mem_write  input  1  D-cache write-back request
d_mem_addr  input  ADDR_W  D-cache block address
d_mem_wdata  input  DATA_W  D-cache write block
d_mem_rdata  output  DATA_W  read block to D-cache
d_mem_ready  output  1  completion pulse to D-cache
mem_read  output  1  read request to memory
mem_write  output  1  write request to memory
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_rdata  input  DATA_W  read data from memory
mem_ready  input  1  memory completion, 1-cycle pulse
grant  output  2  debug: 2'b01 = I granted, 2'b10 = D granted, 2'b00 = none

Behaviour:
- State register values: IDLE, GNT_I, GNT_D, TURN. Reset (proc_reset_n=0 at clock edge) forces IDLE. Reset mid-transaction abandons the grant with no ready pulse.
- Requests:
  - req_i = i_mem_read | i_mem_write
  - req_d = d_mem_read | d_mem_write
- IDLE:
  - Memory outputs: all zero (mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0).
  - Both *_mem_ready = 0. grant = 00.
  - Next state: if req_d and the selection picks D -> GNT_D; else if req_i -> GNT_I; else stay in IDLE.
  - Default selection (macro undefined): fixed priority, D wins ties.
- GNT_x:
  - mem_read, mem_write, mem_addr, mem_wdata are combinational copies of master x's signals.
  - x_mem_ready = mem_ready. The other master's ready is 0.
  - grant reflects x.
  - mem_ready=1 -> TURN.
  - Master x drops req_x before ready (abort) -> IDLE, with no ready forwarded.
- TURN: exactly one cycle with outputs as in IDLE, then -> IDLE. This guarantees memory sees the request low for at least one cycle between transactions and gives the cache one cycle to advance its FSM.
- Latency:
  - Request to first mem_read/mem_write visible at memory: 1 cycle from IDLE.
  - Back-to-back transactions (e.g. D write-back followed by D allocate): ready, then TURN, then IDLE, then GNT. The minimum gap is 2 cycles of request-low at memory.
- i_mem_rdata and d_mem_rdata: both equal mem_rdata unconditionally. They are only meaningful with the matching ready.
- Simultaneous mem_ready in IDLE/TURN (spurious): ignored, not forwarded.
- mem_read and mem_write both asserted by one master: forwarded unchanged; no checking.
- Non-granted master request changes during a grant: no effect until the next IDLE.

Optional Feature:
MEM_ARB_RR_EN
- Defined:
  - Adds a 1-bit last_grant register, reset to I.
  - In IDLE with both requesting, the master not equal to last_grant wins.
  - last_grant updates on entry to GNT_I/GNT_D.
  - A single requester always wins.
- Undefined: no register; fixed D-over-I priority as above.

Test Plan:
- Reset: hold proc_reset_n=0 for 2 cycles with both requests high -> mem_read=0, mem_write=0, grant=00, both readies 0. After release, first grant appears one cycle later.
- Single I read: i_mem_read=1, i_mem_addr=28'h0000123. Memory pulses ready 3 cycles later with rdata=128'hA5..A5 -> mem_addr=28'h0000123, i_mem_ready=1 for 1 cycle with i_mem_rdata=A5..A5, d_mem_ready stays 0, then TURN (grant=00).
- Tie, fixed priority: both request in the same cycle -> grant=10 first. After completion plus TURN, grant=01. With MEM_ARB_RR_EN, the first tie after reset grants D; a second tie grants I.
- D write-back then allocate: d_mem_write=1, addr=28'h0000040, wdata=128'h1111... Ready, then d_mem_read=1, addr=28'h0000080 -> memory sees the write, 2 request-low cycles, then the read. A pending I request waits throughout in fixed mode.
- Abort: I granted, i_mem_read drops before mem_ready -> next cycle IDLE, grant=00, no i_mem_ready. A late mem_ready pulse is not forwarded.
- Reset mid-grant: proc_reset_n=0 while in GNT_D -> next cycle all memory outputs 0, grant=00, and any mem_ready in the reset cycle is not forwarded.
